// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-to-APB bridge slave port among NUM_M masters.
// Define ARB_HLOCK_EN to let M_Hlock hold the grant across a dropped request.
module ahb_bridge_arbiter #(
    parameter int NUM_M = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                Hclk,
    input  logic                Hreset,
    input  logic [NUM_M-1:0]    M_Hbusreq,
    input  logic [NUM_M-1:0]    M_Hlock,
    input  logic [2*NUM_M-1:0]  M_Htrans,
    input  logic [NUM_M-1:0]    M_Hwrite,
    input  logic [AW*NUM_M-1:0] M_Haddr,
    input  logic [DW*NUM_M-1:0] M_HWdata,
    output logic [NUM_M-1:0]    M_Hgrant,
    output logic [1:0]          Htrans,
    output logic                Hwrite,
    output logic [AW-1:0]       Haddr,
    output logic [DW-1:0]       HWdata,
    output logic                Hreadyin,
    input  logic                Hreadyout,
    input  logic [1:0]          Hresp_i,
    input  logic [DW-1:0]       HRdata_i,
    output logic                M_Hready,
    output logic [1:0]          M_Hresp,
    output logic [DW-1:0]       M_HRdata,
    output logic [2:0]          Hmaster
);

    typedef enum logic {FSM_IDLE, FSM_OWN} state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [2:0]       rr_q, rr_d;
    logic [2:0]       down_q, down_d;
    logic             dval_q, dval_d;
    logic [2:0]       own_idx, rr_nxt;
    logic             own_req, own_lock, release_ok;

    // First requester at or after ptr, wrapping modulo NUM_M.
    function automatic logic [NUM_M-1:0] pick(input logic [NUM_M-1:0] req,
                                              input logic [2:0] ptr);
        logic [NUM_M-1:0] g;
        int idx;
        g = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (req[idx]) begin
                g      = '0;
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        own_idx  = '0;
        Htrans   = 2'b00;
        Hwrite   = 1'b0;
        Haddr    = '0;
        own_req  = 1'b0;
        own_lock = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) begin
                own_idx = 3'(i);
                Htrans  = M_Htrans[2*i +: 2];
                Hwrite  = M_Hwrite[i];
                Haddr   = M_Haddr[AW*i +: AW];
                own_req = M_Hbusreq[i];
`ifdef ARB_HLOCK_EN
                own_lock = M_Hlock[i];
`endif
            end
        end
    end

`ifndef ARB_HLOCK_EN
    logic unused_lock;
    assign unused_lock = ^M_Hlock;
`endif

    always_comb begin
        HWdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (dval_q && down_q == 3'(i)) HWdata = M_HWdata[DW*i +: DW];
        end
    end

    assign rr_nxt     = (own_idx == 3'(NUM_M - 1)) ? 3'd0 : own_idx + 3'd1;
    // A SEQ/BUSY owner is mid-burst, so only IDLE or a final NONSEQ may hand over.
    assign release_ok = Hreadyout && !own_req && !own_lock &&
                        (Htrans == 2'b00 || Htrans == 2'b10);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        down_d  = down_q;
        dval_d  = dval_q;
        if (Hreadyout) begin
            if (Htrans[1]) begin
                down_d = own_idx;
                dval_d = 1'b1;
            end else begin
                dval_d = 1'b0;
            end
            if (state_q == FSM_IDLE) begin
                if (|M_Hbusreq) begin
                    grant_d = pick(M_Hbusreq, rr_q);
                    state_d = FSM_OWN;
                end
            end else if (release_ok) begin
                rr_d    = rr_nxt;
                grant_d = pick(M_Hbusreq, rr_nxt);
                state_d = (|M_Hbusreq) ? FSM_OWN : FSM_IDLE;
            end
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= FSM_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            down_q  <= '0;
            dval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            down_q  <= down_d;
            dval_q  <= dval_d;
        end
    end

    assign M_Hgrant = grant_q;
    assign Hmaster  = down_q;
    assign Hreadyin = Hreadyout;
    assign M_Hready = Hreadyout;
    assign M_Hresp  = Hresp_i;
    assign M_HRdata = HRdata_i;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter: grant order, burst hold,
// wait states, data-phase routing via a scoreboard, lock and async reset.
`timescale 1ns/1ps
module tb_ahb_bridge_arbiter;

    localparam int NUM_M = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic                Hclk = 1'b0;
    logic                Hreset = 1'b1;
    logic [NUM_M-1:0]    M_Hbusreq = '0;
    logic [NUM_M-1:0]    M_Hlock = '0;
    logic [2*NUM_M-1:0]  M_Htrans = '0;
    logic [NUM_M-1:0]    M_Hwrite = '0;
    logic [AW*NUM_M-1:0] M_Haddr = '0;
    logic [DW*NUM_M-1:0] M_HWdata = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    logic [NUM_M-1:0]    M_Hgrant;
    logic [1:0]          Htrans;
    logic                Hwrite;
    logic [AW-1:0]       Haddr;
    logic [DW-1:0]       HWdata;
    logic                Hreadyin;
    logic                Hreadyout = 1'b1;
    logic [1:0]          Hresp_i = 2'b00;
    logic [DW-1:0]       HRdata_i = '0;
    logic                M_Hready;
    logic [1:0]          M_Hresp;
    logic [DW-1:0]       M_HRdata;
    logic [2:0]          Hmaster;

    ahb_bridge_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) dut (
        .Hclk(Hclk), .Hreset(Hreset),
        .M_Hbusreq(M_Hbusreq), .M_Hlock(M_Hlock), .M_Htrans(M_Htrans),
        .M_Hwrite(M_Hwrite), .M_Haddr(M_Haddr), .M_HWdata(M_HWdata),
        .M_Hgrant(M_Hgrant), .Htrans(Htrans), .Hwrite(Hwrite),
        .Haddr(Haddr), .HWdata(HWdata), .Hreadyin(Hreadyin),
        .Hreadyout(Hreadyout), .Hresp_i(Hresp_i), .HRdata_i(HRdata_i),
        .M_Hready(M_Hready), .M_Hresp(M_Hresp), .M_HRdata(M_HRdata),
        .Hmaster(Hmaster)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        int          m;
        logic [31:0] d;
    } sb_t;

    sb_t         sb[$];
    bit          pend = 1'b0;
    bit          tb_av = 1'b0;
    int          tb_am = 0;
    logic [31:0] tb_ad = '0;
    int          n_run = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Accepted address phases become expected data phases.
    always @(posedge Hclk) begin
        if (Hreset) begin
            pend = 1'b0;
            sb.delete();
        end else if (Hreadyout) begin
            if (pend && sb.size() > 0) void'(sb.pop_front());
            pend = tb_av;
            if (tb_av) sb.push_back('{m: tb_am, d: tb_ad});
        end
    end

    always @(posedge Hclk) begin
        #1;
        if (pend && sb.size() > 0) M_HWdata[sb[0].m*DW +: DW] = sb[0].d;
    end

    always @(negedge Hclk) begin
        if (!Hreset) begin
            if (pend && sb.size() > 0) begin
                check("dphase_hwdata", HWdata, sb[0].d);
                check("dphase_hmaster", Hmaster, 3'(sb[0].m));
            end else if (!pend) begin
                check("idle_hwdata", HWdata, 0);
            end
        end
    end

    task automatic drive_addr(input int m, input logic [1:0] t,
                              input logic [31:0] a, input logic [31:0] d);
        M_Htrans[2*m +: 2] = t;
        M_Haddr[AW*m +: AW] = a;
        M_Hwrite[m] = 1'b1;
        tb_av = 1'b1;
        tb_am = m;
        tb_ad = d;
    endtask

    task automatic wait_grant(input logic [NUM_M-1:0] exp);
        for (int i = 0; i < 16 && M_Hgrant == '0; i++) begin
            @(posedge Hclk);
            #1;
        end
        check("grant", M_Hgrant, exp);
    endtask

    task automatic issue(input int m, input logic [31:0] a,
                         input logic [31:0] d, input bit rera);
        drive_addr(m, T_NSEQ, a, d);
        M_Hbusreq[m] = 1'b0;
        #1;
        check("addr_htrans", Htrans, T_NSEQ);
        check("addr_haddr", Haddr, a);
        check("addr_hwrite", Hwrite, 1);
        @(posedge Hclk);
        #1;
        M_Htrans[2*m +: 2] = T_IDLE;
        tb_av = 1'b0;
        if (rera) M_Hbusreq[m] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int order[4] = '{0, 1, 2, 0};

    initial begin
        repeat (3) begin
            @(posedge Hclk);
            #1;
            check("rst_grant", M_Hgrant, 0);
            check("rst_htrans", Htrans, 0);
            check("rst_hmaster", Hmaster, 0);
        end
        Hreset = 1'b0;
        repeat (3) begin
            @(posedge Hclk);
            #1;
            check("idle_grant", M_Hgrant, 0);
            check("idle_htrans", Htrans, 0);
            check("idle_hmaster", Hmaster, 0);
        end

        // single write from master0, exact one-cycle grant latency
        M_Hbusreq = 3'b001;
        @(posedge Hclk);
        #1;
        check("m0_grant", M_Hgrant, 3'b001);
        check("m0_pending_htrans", Htrans, T_IDLE);
        issue(0, 32'h8000_0000, 32'hA5A5_A5A5, 1'b0);
        check("m0_released", M_Hgrant, 0);
        @(posedge Hclk);
        #1;

        // restart rr pointer at 0 for the wrap test
        Hreset = 1'b1;
        @(posedge Hclk);
        #1;
        Hreset = 1'b0;
        M_Hbusreq = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(3'(1 << order[k]));
            issue(order[k], 32'h4000_0000 + 32'(k * 16),
                  32'h1000_0000 * 32'(order[k] + 1) + 32'(k), k == 0);
        end
        check("rr_done_grant", M_Hgrant, 0);

        Hresp_i = 2'b01;
        HRdata_i = 32'h1234_5678;
        #1;
        check("resp_pass", M_Hresp, 2'b01);
        check("rdata_pass", M_HRdata, 32'h1234_5678);
        check("ready_pass", M_Hready, 1);
        Hresp_i = 2'b00;
        @(posedge Hclk);
        #1;

        // master1 4-beat burst with two wait states, master2 waiting
        M_Hbusreq = 3'b110;
        wait_grant(3'b010);
        for (int k = 0; k < 4; k++) begin
            drive_addr(1, k == 0 ? T_NSEQ : T_SEQ, 32'h2000_0000 + 32'(4 * k),
                       32'hB000_0000 + 32'(k));
            M_Hbusreq[1] = (k < 3);
            if (k == 2) begin
                Hreadyout = 1'b0;
                repeat (2) begin
                    #1;
                    check("stall_grant", M_Hgrant, 3'b010);
                    check("stall_htrans", Htrans, T_SEQ);
                    check("stall_readyin", Hreadyin, 0);
                    @(posedge Hclk);
                    #1;
                end
                Hreadyout = 1'b1;
            end
            #1;
            check("burst_htrans", Htrans, k == 0 ? T_NSEQ : T_SEQ);
            check("burst_haddr", Haddr, 32'h2000_0000 + 32'(4 * k));
            @(posedge Hclk);
            #1;
        end
        M_Htrans[3:2] = T_IDLE;
        tb_av = 1'b0;
        check("burst_last_grant", M_Hgrant, 3'b010);
        @(posedge Hclk);
        #1;
        check("burst_handover", M_Hgrant, 3'b100);

        // reset during master2 data phase
        issue(2, 32'h3000_0000, 32'hC3C3_C3C3, 1'b0);
        #1;
        check("pre_rst_hwdata", HWdata, 32'hC3C3_C3C3);
        Hreset = 1'b1;
        #1;
        check("midrst_grant", M_Hgrant, 0);
        check("midrst_htrans", Htrans, 0);
        check("midrst_hwdata", HWdata, 0);
        check("midrst_hmaster", Hmaster, 0);
        @(posedge Hclk);
        #1;
        Hreset = 1'b0;

        // restart from master0; lock holds the grant only when enabled
        M_Hbusreq = 3'b011;
        M_Hlock = 3'b001;
        @(posedge Hclk);
        #1;
        check("restart_grant", M_Hgrant, 3'b001);
        M_Hbusreq[0] = 1'b0;
`ifdef ARB_HLOCK_EN
        repeat (3) begin
            @(posedge Hclk);
            #1;
            check("lock_hold", M_Hgrant, 3'b001);
        end
        M_Hlock = '0;
`endif
        @(posedge Hclk);
        #1;
        check("lock_release", M_Hgrant, 3'b010);
        M_Hbusreq = '0;
        M_Hlock = '0;
        @(posedge Hclk);
        #1;
        check("final_idle", M_Hgrant, 0);
        repeat (2) @(posedge Hclk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
